// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data-side memory controller: FSM states,
// lane geometry and a byte-lane extraction helper.
package data_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int LANE_W = 8;
  localparam int LANES  = 4;

  function automatic logic [LANE_W-1:0] lane_byte(input logic [31:0] word,
                                                  input logic [1:0]  lane);
    return word[{lane, 3'b000} +: LANE_W];
  endfunction

endpackage

// File: rtl/data_mem_ctrl_lane_pick.sv
// Combinational priority picker: reports whether any lane is set in the mask
// and the index of the lowest set lane.
module data_mem_ctrl_lane_pick (
  input  logic [3:0] mask,
  output logic       found,
  output logic [1:0] lane
);

  always_comb begin
    found = |mask;
    lane  = 2'd0;
    // Scan downwards so the lowest set bit wins.
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) lane = 2'(i);
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-side memory controller: serialises a word request from the MEM stage
// into byte transactions on a ready-handshaked RAM port, stalling until done.
module data_mem_ctrl #(
  parameter int RAM_AW  = 17,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [3:0]        sel_i,
  input  logic [31:0]       wdata_i,
  input  logic              hold_i,
  output logic [31:0]       rdata_o,
  output logic              stall_req,
  output logic              err_o,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic              ram_re,
  output logic              ram_we,
  input  logic              ram_ready
);
  import data_mem_ctrl_pkg::*;

  localparam int CNT_W = 16;

  state_t            state, state_next;
  logic [3:0]        mask, mask_next, mask_left, pick_src;
  logic [1:0]        lane, lane_next, pick_lane;
  logic              pick_found;
  logic [31:0]       acc, acc_next, rdata_next;
  logic [31:0]       wdata_lat, wdata_lat_next;
  logic [RAM_AW-3:0] base, base_next;
  logic              we_lat, we_lat_next;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_next;
  logic              err_next, re_next, wr_next, timed_out;
  logic [RAM_AW-1:0] ram_addr_next;
  logic [7:0]        ram_dout_next;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{addr_i[31:RAM_AW], addr_i[1:0]};

  // In IDLE the picker looks at the incoming request, otherwise at the pending mask.
  assign pick_src = (state == ST_IDLE) ? sel_i : mask;

  data_mem_ctrl_lane_pick u_lane_pick (
    .mask  (pick_src),
    .found (pick_found),
    .lane  (pick_lane)
  );

  assign mask_left = mask & ~(4'b0001 << lane);
  assign timed_out = (TIMEOUT > 0) && (ram_re || ram_we) && !ram_ready &&
                     (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign stall_req = ce_i & (state != ST_DONE) & ~rst;

  always_comb begin
    state_next     = state;
    mask_next      = mask;
    lane_next      = lane;
    acc_next       = acc;
    rdata_next     = rdata_o;
    wdata_lat_next = wdata_lat;
    base_next      = base;
    we_lat_next    = we_lat;
    wait_cnt_next  = wait_cnt;
    err_next       = err_o;
    re_next        = ram_re;
    wr_next        = ram_we;
    ram_addr_next  = ram_addr;
    ram_dout_next  = ram_dout;
    case (state)
      ST_IDLE: begin
        if (ce_i) begin
          base_next      = addr_i[RAM_AW-1:2];
          we_lat_next    = we_i;
          wdata_lat_next = wdata_i;
          mask_next      = sel_i;
          acc_next       = '0;
          wait_cnt_next  = '0;
          if (pick_found) begin
            state_next    = ST_BUSY;
            lane_next     = pick_lane;
            re_next       = ~we_i;
            wr_next       = we_i;
            ram_addr_next = {addr_i[RAM_AW-1:2], pick_lane};
            ram_dout_next = lane_byte(wdata_i, pick_lane);
          end else begin
            state_next = ST_DONE;
            rdata_next = acc_next;
          end
        end
      end
      ST_BUSY: begin
        if (ram_re || ram_we) begin
          if (ram_ready || timed_out) begin
            re_next       = 1'b0;
            wr_next       = 1'b0;
            wait_cnt_next = '0;
            mask_next     = mask_left;
            if (!we_lat) acc_next[{lane, 3'b000} +: LANE_W] = ram_ready ? ram_din : 8'hFF;
            if (!ram_ready) err_next = 1'b1;
            if (mask_left == 4'b0000) begin
              state_next = ST_DONE;
              rdata_next = acc_next;
            end
          end else begin
            wait_cnt_next = wait_cnt + CNT_W'(1);
          end
        end else begin
          // Gap cycle between bytes: launch the next pending lane.
          lane_next     = pick_lane;
          re_next       = ~we_lat;
          wr_next       = we_lat;
          ram_addr_next = {base, pick_lane};
          ram_dout_next = lane_byte(wdata_lat, pick_lane);
        end
      end
      ST_DONE: begin
        if (!hold_i) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      mask      <= '0;
      lane      <= '0;
      acc       <= '0;
      rdata_o   <= '0;
      wdata_lat <= '0;
      base      <= '0;
      we_lat    <= 1'b0;
      wait_cnt  <= '0;
      err_o     <= 1'b0;
      ram_re    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_dout  <= '0;
    end else begin
      state     <= state_next;
      mask      <= mask_next;
      lane      <= lane_next;
      acc       <= acc_next;
      rdata_o   <= rdata_next;
      wdata_lat <= wdata_lat_next;
      base      <= base_next;
      we_lat    <= we_lat_next;
      wait_cnt  <= wait_cnt_next;
      err_o     <= err_next;
      ram_re    <= re_next;
      ram_we    <= wr_next;
      ram_addr  <= ram_addr_next;
      ram_dout  <= ram_dout_next;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: expected RAM byte operations and word
// results are queued by the stimulus and checked by independent monitors.
module tb_data_mem_ctrl;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } res_t;

  typedef struct packed {
    logic        we;
    logic [16:0] addr;
    logic [7:0]  data;
  } ram_op_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce_i = 1'b0, we_i = 1'b0, hold_i = 1'b0;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic [3:0]  sel_i = '0;
  logic [31:0] rdata_o;
  logic        stall_req, err_o;
  logic [16:0] ram_addr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = '0;
  logic        ram_re, ram_we;
  logic        ram_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  res_t    res_q[$];
  ram_op_t ram_q[$];

  int ram_waits = 0;
  bit ram_never = 1'b0;
  logic [7:0] ram_mem [0:1023];

  data_mem_ctrl #(.RAM_AW(17), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce_i      (ce_i),
    .we_i      (we_i),
    .addr_i    (addr_i),
    .sel_i     (sel_i),
    .wdata_i   (wdata_i),
    .hold_i    (hold_i),
    .rdata_o   (rdata_o),
    .stall_req (stall_req),
    .err_o     (err_o),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .ram_din   (ram_din),
    .ram_re    (ram_re),
    .ram_we    (ram_we),
    .ram_ready (ram_ready)
  );

  always #5 clk = ~clk;

  // RAM model with programmable wait states; checks every completed byte op.
  initial begin
    int wcnt;
    ram_op_t got, exp;
    wcnt = 0;
    for (int i = 0; i < 1024; i++) ram_mem[i] = 8'h00;
    ram_mem[10'h100] = 8'h44; ram_mem[10'h101] = 8'h33;
    ram_mem[10'h102] = 8'h22; ram_mem[10'h103] = 8'h11;
    ram_mem[10'h302] = 8'hEF; ram_mem[10'h303] = 8'hBE;
    forever begin
      @(posedge clk); #1;
      ram_ready = 1'b0;
      if (rst || !(ram_re || ram_we)) begin
        wcnt = 0;
      end else if (!ram_never && wcnt == ram_waits) begin
        wcnt = 0;
        ram_ready = 1'b1;
        if (ram_we) ram_mem[ram_addr[9:0]] = ram_dout;
        else        ram_din = ram_mem[ram_addr[9:0]];
        got.we = ram_we; got.addr = ram_addr; got.data = ram_we ? ram_dout : ram_din;
        $display("ram  %s addr=%05h data=%02h", got.we ? "WR" : "RD", got.addr, got.data);
        checks++;
        if (ram_q.size() == 0) begin
          errors++;
          $display("FAIL ram_op unexpected: got we=%0b addr=%05h data=%02h, expected none",
                   got.we, got.addr, got.data);
        end else begin
          exp = ram_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL ram_op: got we=%0b addr=%05h data=%02h, expected we=%0b addr=%05h data=%02h",
                     got.we, got.addr, got.data, exp.we, exp.addr, exp.data);
          end
        end
      end else begin
        wcnt++;
      end
    end
  end

  // Result monitor: compares once on the first DONE cycle of each request.
  initial begin
    bit done_seen;
    res_t exp;
    done_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (ce_i && !stall_req && !rst) begin
        if (!done_seen) begin
          done_seen = 1'b1;
          checks++;
          $display("done rdata=%08h err=%0b", rdata_o, err_o);
          if (res_q.size() == 0) begin
            errors++;
            $display("FAIL result unexpected: got rdata=%08h err=%0b, expected none", rdata_o, err_o);
          end else begin
            exp = res_q.pop_front();
            if (rdata_o !== exp.rdata || err_o !== exp.err) begin
              errors++;
              $display("FAIL result: got rdata=%08h err=%0b, expected rdata=%08h err=%0b",
                       rdata_o, err_o, exp.rdata, exp.err);
            end
          end
        end
      end else begin
        done_seen = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h", name, got, exp);
    end
  endtask

  task automatic exp_ram(input logic we, input logic [16:0] addr, input logic [7:0] data);
    ram_op_t op;
    op.we = we; op.addr = addr; op.data = data;
    ram_q.push_back(op);
  endtask

  task automatic run_req(input string name, input logic we, input logic [31:0] addr,
                         input logic [3:0] sel, input logic [31:0] wdata, input int waits,
                         input int exp_cycles, input int hold_cycles,
                         input logic [31:0] exp_rdata, input logic exp_err);
    int   n;
    bit   done;
    res_t r;
    r.rdata = exp_rdata; r.err = exp_err;
    res_q.push_back(r);
    ram_waits = waits;
    @(negedge clk); #2;
    ce_i = 1'b1; we_i = we; addr_i = addr; sel_i = sel; wdata_i = wdata;
    hold_i = (hold_cycles > 0);
    #1;
    check({name, " stall_at_ce"}, {31'd0, stall_req}, 32'd1);
    n = 1; done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      n++;
      if (!stall_req) done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s done_timeout: got no DONE, expected DONE within 200 cycles", name);
    end else begin
      check({name, " ce_to_done_cycles"}, n, exp_cycles);
    end
    for (int h = 0; h < hold_cycles; h++) begin
      @(negedge clk);
      check({name, " hold_rdata"}, rdata_o, exp_rdata);
      check({name, " hold_quiet"}, {29'd0, stall_req, ram_re, ram_we}, 32'd0);
    end
    #2;
    ce_i = 1'b0; hold_i = 1'b0; sel_i = 4'b0000;
    $display("req  %s we=%0b addr=%08h sel=%04b cycles=%0d", name, we, addr, sel, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("reset rdata_o", rdata_o, 32'd0);
    check("reset flags", {28'd0, err_o, stall_req, ram_re, ram_we}, 32'd0);
    check("reset ram_addr", {15'd0, ram_addr}, 32'd0);

    exp_ram(0, 17'h100, 8'h44); exp_ram(0, 17'h101, 8'h33);
    exp_ram(0, 17'h102, 8'h22); exp_ram(0, 17'h103, 8'h11);
    run_req("LW_w1", 0, 32'h100, 4'b1111, 32'h0, 1, 13, 0, 32'h11223344, 0);

    exp_ram(1, 17'h203, 8'hAB);
    run_req("SB", 1, 32'h203, 4'b1000, 32'hABABABAB, 0, 3, 0, 32'h0, 0);

    exp_ram(0, 17'h302, 8'hEF); exp_ram(0, 17'h303, 8'hBE);
    run_req("LH_w3", 0, 32'h300, 4'b1100, 32'h0, 3, 11, 0, 32'hBEEF0000, 0);

    run_req("sel0", 0, 32'h104, 4'b0000, 32'h0, 0, 2, 0, 32'h0, 0);

    exp_ram(0, 17'h100, 8'h44); exp_ram(0, 17'h101, 8'h33);
    exp_ram(0, 17'h102, 8'h22); exp_ram(0, 17'h103, 8'h11);
    run_req("LW_hold", 0, 32'h100, 4'b1111, 32'h0, 0, 9, 3, 32'h11223344, 0);
    @(negedge clk);
    check("after_hold idle", {29'd0, stall_req, ram_re, ram_we}, 32'd0);

    exp_ram(0, 17'h102, 8'h22);
    run_req("LB_lane2", 0, 32'h100, 4'b0100, 32'h0, 2, 5, 0, 32'h00220000, 0);

    ram_never = 1'b1;
    run_req("LB_timeout", 0, 32'h500, 4'b0001, 32'h0, 0, 6, 0, 32'h000000FF, 1);
    ram_never = 1'b0;

    exp_ram(0, 17'h101, 8'h33);
    run_req("LB_sticky", 0, 32'h100, 4'b0010, 32'h0, 0, 3, 0, 32'h00003300, 1);

    ram_waits = 2;
    @(negedge clk); #2;
    ce_i = 1'b1; we_i = 1'b0; addr_i = 32'h100; sel_i = 4'b1111;
    @(negedge clk);
    check("midbusy ram_re", {31'd0, ram_re}, 32'd1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("abort strobes", {30'd0, ram_re, ram_we}, 32'd0);
    check("abort stall", {31'd0, stall_req}, 32'd0);
    check("abort err", {31'd0, err_o}, 32'd0);
    @(negedge clk); #2;
    rst = 1'b0; ce_i = 1'b0; sel_i = 4'b0000;
    $display("req  reset_abort addr=00000100");

    exp_ram(1, 17'h400, 8'h0D); exp_ram(1, 17'h401, 8'hF0);
    exp_ram(1, 17'h402, 8'hFE); exp_ram(1, 17'h403, 8'hCA);
    run_req("SW_after_rst", 1, 32'h400, 4'b1111, 32'hCAFEF00D, 0, 9, 0, 32'h0, 0);

    exp_ram(0, 17'h400, 8'h0D); exp_ram(0, 17'h401, 8'hF0);
    exp_ram(0, 17'h402, 8'hFE); exp_ram(0, 17'h403, 8'hCA);
    run_req("LW_readback", 0, 32'h400, 4'b1111, 32'h0, 1, 13, 0, 32'hCAFEF00D, 0);

    exp_ram(1, 17'h204, 8'h34); exp_ram(1, 17'h205, 8'h12);
    run_req("SH_low", 1, 32'h204, 4'b0011, 32'h12341234, 0, 5, 0, 32'h0, 0);

    repeat (5) @(negedge clk);
    check("ram_q drained", ram_q.size(), 32'd0);
    check("res_q drained", res_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
